sdcard_ctrlmod: RTL and testbench
=================================

# sdcard_ctrlmod

Sequencer for the SD-card SPI byte/command engine (`sdcard_funcmod`). It runs card initialisation and single 512-byte sector reads and writes by issuing command calls and byte calls to the engine. It drives chip select and exchanges sector data with an external 512×8 buffer through an address/strobe port. It sits between the application (or file-system logic) and the engine, and is the only master of the engine.

## Interface
- No parameters. Fixed constants are in the package, see Structure.
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- iCall  in  3  request, held high until oDone:
  - [2] init
  - [1] write sector
  - [0] read sector
  - More than one bit set is illegal; priority is [2] > [1] > [0].
- oDone  out  1  one-cycle completion pulse.
- iAddr  in  32  sector byte address, sampled at call start.
- oErr  out  1  error flag of the last operation, valid with oDone.
- oBufAddr  out  9  buffer byte index.
- oBufWr  out  1  buffer write strobe (read sector).
- oBufData  out  8  byte to the buffer.
- iBufData  in  8  byte from the buffer. One-cycle read latency from oBufAddr.
- SD_NCS  out  1  card chip select, active low.
- oFuncCall  out  2  to engine:
  - [1] command call
  - [0] byte call
- iFuncDone  in  1  engine done pulse.
- oFuncAddr  out  48  engine command word {cmd, arg[31:0], crc}.
- oFuncData  out  8  engine transmit byte.
- iFuncData  in  8  engine received byte / R1.

## Operation
- Reset values:
  - oDone=0, oErr=0, SD_NCS=1.
  - oFuncCall=0, oFuncAddr=0, oFuncData=8'hFF.
  - oBufAddr=0, oBufWr=0, oBufData=0.
  - State IDLE.
- Engine handshake:
  - Raise exactly one oFuncCall bit and hold oFuncAddr/oFuncData stable.
  - On the edge where iFuncDone is sampled high, clear oFuncCall and latch iFuncData.
  - Do not issue the next call before the following cycle.
  - oFuncAddr must stay stable through the done cycle. The engine switches to high speed when it sees command byte 8'h41 at done.
- Init (iCall[2]):
  - PWRUP: SD_NCS=1; 10 byte calls of 8'hFF, giving 80 clocks.
  - CMD0: SD_NCS=0; command 48'h40_0000_0000_95.
    - R1==8'h01 → CMD1.
    - Otherwise deassert SD_NCS, one 8'hFF byte call, then retry CMD0.
  - CMD1: command 48'h41_0000_0000_FF.
    - R1==8'h00 → FINISH.
    - Otherwise one 8'hFF byte call, then retry.
- Write (iCall[1]):
  - CMD24: 48'h58,iAddr,8'hFF. R1≠8'h00 → error.
  - One 8'hFF gap byte, then token 8'hFE.
  - 512 data bytes from the buffer, index 0..511.
  - Two CRC bytes of 8'hFF.
  - One response byte: (byte&8'h1F)≠8'h05 → error.
  - BUSY: 8'hFF byte calls until the received byte ≠8'h00.
- Read (iCall[0]):
  - CMD17: 48'h51,iAddr,8'hFF. R1≠8'h00 → error.
  - TOKEN: 8'hFF byte calls until the received byte ==8'hFE.
  - 512 byte calls of 8'hFF. Each received byte is written to the buffer: oBufWr pulses one cycle at index k, k=0..511.
  - Two CRC byte calls, discarded.
- FINISH:
  - SD_NCS=1.
  - One 8'hFF byte call (8 trailing clocks).
  - oDone pulses one cycle with oErr.
  - Return to IDLE one cycle later. The requester drops iCall on oDone.
- Error path: the same FINISH sequence with oErr=1. oErr holds until the next call start.
- States: IDLE, PWRUP, CMD0, CMD1, CMD, GAP, TOKEN, DATA, CRC, RESP, BUSY, FINISH, DONE.
- Arithmetic:
  - 9-bit byte index wraps 511→0 exactly at the end of DATA.
  - 4-bit PWRUP counter.
  - 1-bit CRC counter.

## Timing
- Call start: one cycle from iCall sampled high in IDLE to the first oFuncCall.
- Gap between consecutive engine calls: exactly 1 idle cycle.
- Write buffer fetch: oBufAddr=k is presented before byte call k is raised, so iBufData is sampled one cycle after. oFuncData is loaded from iBufData when the call is raised.
- Read buffer write: oBufData/oBufWr are registered on the done edge and valid the next cycle.
- iCall dropped mid-operation is ignored; the sequence completes.
- RESET mid-operation aborts immediately to reset values. The engine must be reset by the same RESET.

## Configuration
- SDCARD_CTRL_TIMEOUT_EN defined:
  - Retry/poll counters apply, with limits in the package:
    - CMD0 retries 16
    - CMD1 retries 4096
    - TOKEN polls 4096
    - BUSY polls 65535
  - Exceeding a limit → FINISH with oErr=1.
- Undefined: all loops retry indefinitely and oErr is set only by bad R1 or a bad data response.

## Structure
- Package sdcard_pkg:
  - state enum
  - command bytes 8'h40/41/51/58
  - CRC bytes 8'h95/8'hFF
  - tokens 8'hFE, 8'h05
  - PWRUP byte count 10
  - timeout limits
- One sub-module is natural: sdcard_cmdbuild, combinational {cmd,arg,crc} assembly from state and iAddr.
- Top level sdcard_basemod instantiates sdcard_ctrlmod and sdcard_funcmod.

## Test plan
- Init, card model answers CMD0→8'h01, CMD1→8'h01 twice then 8'h00:
  - 10 FF bytes sent with SD_NCS=1.
  - 3 CMD1 commands issued.
  - oDone=1, oErr=0.
  - The engine is in high speed afterwards.
- Read at 32'h0000_0200, model sends 8'hFF×3, 8'hFE, then bytes k&8'hFF:
  - 512 oBufWr pulses with oBufAddr=k, oBufData=k[7:0].
  - oErr=0.
- Write, buffer preloaded with k^8'hA5, model response 8'hE5 then busy 8'h00×20:
  - Model captures 8'hFE plus 512 correct bytes.
  - 21 BUSY polls.
  - oDone with oErr=0.
- Write with data response 8'h0B → oErr=1, SD_NCS=1 at oDone.
- CMD17 R1=8'h04 → no buffer writes, oErr=1.
- With SDCARD_CTRL_TIMEOUT_EN, CMD0 always 8'hFF → exactly 16 CMD0 commands, then oErr=1. Assert RESET mid-DATA → all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/sdcard_pkg.sv
// sdcard_pkg -- shared types and constants for the SD-card SPI sequencer.
//   state_t       : sequencer states
//   CMD_* / CRC_* : command-frame bytes
//   TOKEN / R1    : data tokens, response masks and expected R1 values
//   *_TRIES/POLLS : retry and poll limits, used when SDCARD_CTRL_TIMEOUT_EN is defined
package sdcard_pkg;

  typedef enum logic [3:0] {
    IDLE, PWRUP, CMD0, CMD1, CMD, GAP, TOKEN, DATA, CRC, RESP, BUSY, FINISH, DONE
  } state_t;

  localparam logic [7:0] CMD_GO_IDLE    = 8'h40;
  localparam logic [7:0] CMD_SEND_OP    = 8'h41;
  localparam logic [7:0] CMD_READ       = 8'h51;
  localparam logic [7:0] CMD_WRITE      = 8'h58;
  localparam logic [7:0] CRC_CMD0       = 8'h95;
  localparam logic [7:0] CRC_NONE       = 8'hFF;

  localparam logic [7:0] BYTE_IDLE      = 8'hFF;
  localparam logic [7:0] TOKEN_START    = 8'hFE;
  localparam logic [7:0] DATA_RESP_OK   = 8'h05;
  localparam logic [7:0] DATA_RESP_MASK = 8'h1F;
  localparam logic [7:0] R1_IDLE        = 8'h01;
  localparam logic [7:0] R1_READY       = 8'h00;
  localparam logic [7:0] BUSY_LOW       = 8'h00;

  localparam logic [3:0] PWRUP_BYTES    = 4'd10;

  localparam logic [15:0] CMD0_TRIES    = 16'd16;
  localparam logic [15:0] CMD1_TRIES    = 16'd4096;
  localparam logic [15:0] TOKEN_POLLS   = 16'd4096;
  localparam logic [15:0] BUSY_POLLS    = 16'd65535;

endpackage

// File: rtl/sdcard_ctrlmod_cmdbuild.sv
// sdcard_cmdbuild -- combinational assembly of the 48-bit command word
// {cmd, arg[31:0], crc} for the command-issuing states.
//   state    : current sequencer state
//   is_write : selects CMD24 over CMD17 in state CMD
//   addr     : sector byte address latched at call start
//   cmd_word : command word for the engine (zero outside command states)
module sdcard_cmdbuild
  import sdcard_pkg::*;
(
  input  state_t      state,
  input  logic        is_write,
  input  logic [31:0] addr,
  output logic [47:0] cmd_word
);

  always_comb begin
    case (state)
      CMD0:    cmd_word = {CMD_GO_IDLE, 32'h0, CRC_CMD0};
      CMD1:    cmd_word = {CMD_SEND_OP, 32'h0, CRC_NONE};
      CMD:     cmd_word = {(is_write ? CMD_WRITE : CMD_READ), addr, CRC_NONE};
      default: cmd_word = '0;
    endcase
  end

endmodule

// File: rtl/sdcard_ctrlmod.sv
// sdcard_ctrlmod -- sequencer for the SD-card SPI engine: card init and
// single 512-byte sector read/write.
//   CLOCK/RESET      : clock, asynchronous active-low reset
//   iCall/oDone/oErr : request {init,write,read}, completion pulse, error flag
//   iAddr            : sector byte address, sampled at call start
//   oBufAddr/oBufWr/oBufData/iBufData : 512x8 buffer port (1-cycle read latency)
//   SD_NCS           : card chip select, active low
//   oFuncCall/iFuncDone/oFuncAddr/oFuncData/iFuncData : engine handshake
// Optional feature macro: SDCARD_CTRL_TIMEOUT_EN bounds every retry/poll loop.
module sdcard_ctrlmod
  import sdcard_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [2:0]  iCall,
  output logic        oDone,
  input  logic [31:0] iAddr,
  output logic        oErr,
  output logic [8:0]  oBufAddr,
  output logic        oBufWr,
  output logic [7:0]  oBufData,
  input  logic [7:0]  iBufData,
  output logic        SD_NCS,
  output logic [1:0]  oFuncCall,
  input  logic        iFuncDone,
  output logic [47:0] oFuncAddr,
  output logic [7:0]  oFuncData,
  input  logic [7:0]  iFuncData
);

  state_t      state_q, state_d;
  logic        ncs_q, ncs_d;
  logic [1:0]  call_q, call_d;
  logic [47:0] faddr_q, faddr_d;
  logic [7:0]  fdata_q, fdata_d;
  logic [8:0]  buf_addr_q, buf_addr_d;
  logic        buf_wr_q, buf_wr_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [3:0]  pwr_q, pwr_d;
  logic        crc_q, crc_d;
  logic        sub_q, sub_d;   // CMD0/CMD1: 1 = spacer 8'hFF byte before retry
  logic [8:0]  idx_q, idx_d;   // data bytes completed, wraps 511->0

  logic [47:0] cmd_word;
  logic        done_evt;
  logic        timeout_hit;
  logic        req_cmd, req_byte;
  logic [7:0]  tx_byte;

  sdcard_cmdbuild u_cmdbuild (
    .state    (state_q),
    .is_write (wr_q),
    .addr     (addr_q),
    .cmd_word (cmd_word)
  );

  assign done_evt = iFuncDone && (call_q != 2'b00);

`ifdef SDCARD_CTRL_TIMEOUT_EN
  // Counts failed attempts in the current looping state; restarts on entry.
  logic [15:0] try_q, try_d;

  always_comb begin
    try_d = try_q;
    if (state_d != state_q)      try_d = '0;
    else if (done_evt && !sub_q) try_d = try_q + 16'd1;
  end

  always_comb begin
    case (state_q)
      CMD0:    timeout_hit = (try_q == CMD0_TRIES  - 16'd1);
      CMD1:    timeout_hit = (try_q == CMD1_TRIES  - 16'd1);
      TOKEN:   timeout_hit = (try_q == TOKEN_POLLS - 16'd1);
      BUSY:    timeout_hit = (try_q == BUSY_POLLS  - 16'd1);
      default: timeout_hit = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) try_q <= '0;
    else        try_q <= try_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // What the current state asks of the engine.
  always_comb begin
    req_cmd  = 1'b0;
    req_byte = 1'b0;
    tx_byte  = BYTE_IDLE;
    case (state_q)
      PWRUP, GAP, CRC, RESP, BUSY, FINISH: req_byte = 1'b1;
      CMD0, CMD1: begin
        req_cmd  = !sub_q;
        req_byte = sub_q;
      end
      CMD:   req_cmd = 1'b1;
      TOKEN: begin
        req_byte = 1'b1;
        if (wr_q) tx_byte = TOKEN_START;
      end
      DATA: begin
        req_byte = 1'b1;
        if (wr_q) tx_byte = iBufData;
      end
      default: ;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ncs_d      = ncs_q;
    call_d     = call_q;
    faddr_d    = faddr_q;
    fdata_d    = fdata_q;
    buf_addr_d = buf_addr_q;
    buf_wr_d   = 1'b0;
    buf_data_d = buf_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    pwr_d      = pwr_q;
    crc_d      = crc_q;
    sub_d      = sub_q;
    idx_d      = idx_q;

    case (state_q)
      IDLE: if (iCall != 3'b000) begin
        addr_d     = iAddr;
        err_d      = 1'b0;
        pwr_d      = '0;
        idx_d      = '0;
        crc_d      = 1'b0;
        sub_d      = 1'b0;
        buf_addr_d = '0;
        if (iCall[2]) state_d = PWRUP;
        else begin
          wr_d    = iCall[1];
          state_d = CMD;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    // Raising a call: only from a cycle with no call outstanding, which
    // yields exactly one idle cycle after each done edge.
    if (call_q == 2'b00 && (req_cmd || req_byte)) begin
      if (req_cmd) begin
        call_d  = 2'b10;
        faddr_d = cmd_word;
        if (state_q == CMD0 || state_q == CMD) ncs_d = 1'b0;
      end else begin
        call_d  = 2'b01;
        fdata_d = tx_byte;
      end
      // Pre-fetch the next write byte so it is on iBufData by the next raise.
      if (state_q == DATA && wr_q) buf_addr_d = idx_q + 9'd1;
    end

    if (done_evt) begin
      call_d = 2'b00;
      case (state_q)
        PWRUP: begin
          if (pwr_q == PWRUP_BYTES - 4'd1) state_d = CMD0;
          else                             pwr_d   = pwr_q + 4'd1;
        end
        CMD0: begin
          if (sub_q)                       sub_d   = 1'b0;
          else if (iFuncData == R1_IDLE)   state_d = CMD1;
          else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            sub_d = 1'b1;
            ncs_d = 1'b1;
          end
        end
        CMD1: begin
          if (sub_q)                       sub_d   = 1'b0;
          else if (iFuncData == R1_READY)  state_d = FINISH;
          else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else                         sub_d   = 1'b1;
        end
        CMD: begin
          if (iFuncData != R1_READY) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else state_d = wr_q ? GAP : TOKEN;
        end
        GAP: state_d = TOKEN;
        TOKEN: begin
          if (wr_q || iFuncData == TOKEN_START) state_d = DATA;
          else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end
        DATA: begin
          idx_d = idx_q + 9'd1;
          if (!wr_q) begin
            buf_addr_d = idx_q;
            buf_data_d = iFuncData;
            buf_wr_d   = 1'b1;
          end
          if (idx_q == 9'd511) begin
            state_d = CRC;
            crc_d   = 1'b0;
          end
        end
        CRC: begin
          crc_d = ~crc_q;
          if (crc_q) state_d = wr_q ? RESP : FINISH;
        end
        RESP: begin
          if ((iFuncData & DATA_RESP_MASK) != DATA_RESP_OK) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else state_d = BUSY;
        end
        BUSY: begin
          if (iFuncData != BUSY_LOW) state_d = FINISH;
          else if (timeout_hit) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end
        FINISH: begin
          state_d = DONE;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end

    // Every route into FINISH releases the card before the trailing byte.
    if (state_d == FINISH && state_q != FINISH) begin
      ncs_d = 1'b1;
      sub_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      ncs_q      <= 1'b1;
      call_q     <= 2'b00;
      faddr_q    <= '0;
      fdata_q    <= BYTE_IDLE;
      buf_addr_q <= '0;
      buf_wr_q   <= 1'b0;
      buf_data_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      pwr_q      <= '0;
      crc_q      <= 1'b0;
      sub_q      <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      ncs_q      <= ncs_d;
      call_q     <= call_d;
      faddr_q    <= faddr_d;
      fdata_q    <= fdata_d;
      buf_addr_q <= buf_addr_d;
      buf_wr_q   <= buf_wr_d;
      buf_data_q <= buf_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      pwr_q      <= pwr_d;
      crc_q      <= crc_d;
      sub_q      <= sub_d;
      idx_q      <= idx_d;
    end
  end

  assign oDone     = done_q;
  assign oErr      = err_q;
  assign SD_NCS    = ncs_q;
  assign oFuncCall = call_q;
  assign oFuncAddr = faddr_q;
  assign oFuncData = fdata_q;
  assign oBufAddr  = buf_addr_q;
  assign oBufWr    = buf_wr_q;
  assign oBufData  = buf_data_q;

endmodule

// File: tb/tb_sdcard_ctrlmod.sv
// tb_sdcard_ctrlmod -- self-checking bench for sdcard_ctrlmod with a
// behavioural engine/card model and a 512x8 buffer model.
// Optional macro: SDCARD_CTRL_TIMEOUT_EN enables the CMD0 timeout scenario.
module tb_sdcard_ctrlmod;

  localparam int MAX_CYCLES = 20000;

  typedef enum int {SCN_INIT, SCN_READ, SCN_WRITE, SCN_READ_BADR1, SCN_CMD0_DEAD} scn_t;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [2:0]  iCall;
  logic        oDone;
  logic [31:0] iAddr;
  logic        oErr;
  logic [8:0]  oBufAddr;
  logic        oBufWr;
  logic [7:0]  oBufData;
  logic [7:0]  iBufData;
  logic        SD_NCS;
  logic [1:0]  oFuncCall;
  logic        iFuncDone;
  logic [47:0] oFuncAddr;
  logic [7:0]  oFuncData;
  logic [7:0]  iFuncData;

  sdcard_ctrlmod dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .iCall     (iCall),
    .oDone     (oDone),
    .iAddr     (iAddr),
    .oErr      (oErr),
    .oBufAddr  (oBufAddr),
    .oBufWr    (oBufWr),
    .oBufData  (oBufData),
    .iBufData  (iBufData),
    .SD_NCS    (SD_NCS),
    .oFuncCall (oFuncCall),
    .iFuncDone (iFuncDone),
    .oFuncAddr (oFuncAddr),
    .oFuncData (oFuncData),
    .iFuncData (iFuncData)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- model state ----------------
  scn_t        scn;
  logic [7:0]  resp_byte;
  logic [47:0] last_cmd;
  int          bcnt, cmd0_n, cmd1_n, pwr_ff, pre_bytes, busy_polls, buf_wr_n;
  logic        high_speed;
  logic [7:0]  mem [512];
  logic [7:0]  got_tx [$];
  logic [7:0]  exp_tx [$];
  logic [16:0] exp_wr [$];

  function automatic logic [7:0] engine_reply(input logic is_cmd, input logic [47:0] w,
                                              input logic [7:0] tx, input logic ncs);
    logic [7:0] r;
    int k;
    r = 8'hFF;
    if (is_cmd) begin
      last_cmd = w;
      bcnt     = 0;
      case (w[47:40])
        8'h40: begin cmd0_n++; r = (scn == SCN_CMD0_DEAD) ? 8'hFF : 8'h01; end
        8'h41: begin cmd1_n++; r = (cmd1_n >= 3) ? 8'h00 : 8'h01; end
        8'h51: r = (scn == SCN_READ_BADR1) ? 8'h04 : 8'h00;
        8'h58: r = 8'h00;
        default: r = 8'hFF;
      endcase
    end else begin
      if (last_cmd[47:40] == 8'h00) begin
        pre_bytes++;
        if (ncs && tx == 8'hFF) pwr_ff++;
      end else if (last_cmd[47:40] == 8'h51) begin
        if (bcnt == 3) r = 8'hFE;
        else if (bcnt >= 4 && bcnt < 516) begin
          k = bcnt - 4;
          r = k[7:0];
          exp_wr.push_back({k[8:0], k[7:0]});
        end
      end else if (last_cmd[47:40] == 8'h58) begin
        if (bcnt >= 1 && bcnt <= 513) got_tx.push_back(tx);
        else if (bcnt == 516) r = resp_byte;
        else if (bcnt >= 517) begin
          if (!ncs) busy_polls++;
          r = (bcnt < 537) ? 8'h00 : 8'hFF;
        end
      end
      bcnt++;
    end
    return r;
  endfunction

  // Engine model: done one cycle after a call is seen, then low for a cycle.
  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      iFuncDone <= 1'b0;
      iFuncData <= 8'hFF;
    end else begin
      iFuncDone <= 1'b0;
      if (iFuncDone && oFuncCall[1] && oFuncAddr[47:40] == 8'h41) high_speed = 1'b1;
      if (oFuncCall != 2'b00 && !iFuncDone) begin
        iFuncDone <= 1'b1;
        iFuncData <= engine_reply(oFuncCall[1], oFuncAddr, oFuncData, SD_NCS);
      end
    end
  end

  // Buffer model: registered read, one cycle of latency.
  always @(posedge CLOCK) iBufData <= mem[oBufAddr];

  // Scoreboard for buffer writes during sector reads.
  always @(negedge CLOCK) begin
    if (RESET && oBufWr) begin
      buf_wr_n++;
      if (exp_wr.size() == 0) check("bufwr_unexpected", {oBufAddr, oBufData}, 17'h1FFFF);
      else check("bufwr", {oBufAddr, oBufData}, exp_wr.pop_front());
    end
  end

  task automatic reset_model(input scn_t s);
    scn = s; last_cmd = '0; bcnt = 0; cmd0_n = 0; cmd1_n = 0; pwr_ff = 0;
    pre_bytes = 0; busy_polls = 0; buf_wr_n = 0; high_speed = 1'b0; resp_byte = 8'hE5;
    got_tx.delete(); exp_tx.delete(); exp_wr.delete();
  endtask

  task automatic run_op(input logic [2:0] call, input logic [31:0] addr,
                        output logic err, output logic ncs);
    logic ok;
    ok = 1'b0; err = 1'b0; ncs = 1'b0;
    @(negedge CLOCK);
    iCall = call;
    iAddr = addr;
    for (int n = 0; n < MAX_CYCLES; n++) begin
      @(negedge CLOCK);
      if (oDone) begin
        ok = 1'b1; err = oErr; ncs = SD_NCS;
        break;
      end
    end
    iCall = 3'b000;
    check("op_completed", ok, 1'b1);
    @(negedge CLOCK);
    check("done_one_cycle", oDone, 1'b0);
    check("err_held", oErr, err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done_err_ncs"}, {oDone, oErr, SD_NCS}, 3'b001);
    check({tag, "_fcall"}, oFuncCall, 2'b00);
    check({tag, "_faddr"}, oFuncAddr, 48'h0);
    check({tag, "_fdata"}, oFuncData, 8'hFF);
    check({tag, "_buf"}, {oBufAddr, oBufWr, oBufData}, 18'h0);
  endtask

  logic err, ncs, seen;

  initial begin
    RESET = 1'b0; iCall = 3'b000; iAddr = '0;
    reset_model(SCN_INIT);
    for (int k = 0; k < 512; k++) mem[k] = 8'h00;
    repeat (3) @(negedge CLOCK);
    check_reset_outputs("reset");
    RESET = 1'b1;

    // Init: CMD0 -> 01, CMD1 -> 01, 01, 00.
    reset_model(SCN_INIT);
    run_op(3'b100, 32'h0, err, ncs);
    check("init_err", err, 1'b0);
    check("init_pwrup_ff", pwr_ff, 10);
    check("init_pre_bytes", pre_bytes, 10);
    check("init_cmd0_n", cmd0_n, 1);
    check("init_cmd1_n", cmd1_n, 3);
    check("init_high_speed", high_speed, 1'b1);

    // Sector read at 0x200.
    reset_model(SCN_READ);
    run_op(3'b001, 32'h0000_0200, err, ncs);
    check("rd_cmd_word", last_cmd, 48'h51_0000_0200_FF);
    check("rd_err", err, 1'b0);
    check("rd_bufwr_count", buf_wr_n, 512);
    check("rd_pending", exp_wr.size(), 0);

    // Sector write at 0x400, data k^A5, response E5, 20 busy bytes.
    reset_model(SCN_WRITE);
    exp_tx.push_back(8'hFE);
    for (int k = 0; k < 512; k++) begin
      mem[k] = k[7:0] ^ 8'hA5;
      exp_tx.push_back(k[7:0] ^ 8'hA5);
    end
    run_op(3'b010, 32'h0000_0400, err, ncs);
    check("wr_cmd_word", last_cmd, 48'h58_0000_0400_FF);
    check("wr_tx_count", got_tx.size(), 513);
    while (got_tx.size() != 0 && exp_tx.size() != 0)
      check("wr_tx_byte", got_tx.pop_front(), exp_tx.pop_front());
    check("wr_busy_polls", busy_polls, 21);
    check("wr_err", err, 1'b0);
    check("wr_bufwr_count", buf_wr_n, 0);

    // Write with rejected data response.
    reset_model(SCN_WRITE);
    resp_byte = 8'h0B;
    run_op(3'b010, 32'h0000_0600, err, ncs);
    check("wrbad_err", err, 1'b1);
    check("wrbad_ncs_at_done", ncs, 1'b1);
    check("wrbad_busy_polls", busy_polls, 0);

    // Read with bad R1.
    reset_model(SCN_READ_BADR1);
    run_op(3'b001, 32'h0000_0800, err, ncs);
    check("rdbad_err", err, 1'b1);
    check("rdbad_bufwr_count", buf_wr_n, 0);

`ifdef SDCARD_CTRL_TIMEOUT_EN
    // CMD0 never answers: bounded retries then error.
    reset_model(SCN_CMD0_DEAD);
    run_op(3'b100, 32'h0, err, ncs);
    check("tmo_cmd0_n", cmd0_n, 16);
    check("tmo_err", err, 1'b1);
`endif

    // Reset asserted in the middle of a read's DATA phase.
    reset_model(SCN_READ);
    @(negedge CLOCK);
    iCall = 3'b001;
    iAddr = 32'h0000_0A00;
    seen = 1'b0;
    for (int n = 0; n < MAX_CYCLES; n++) begin
      @(negedge CLOCK);
      if (buf_wr_n >= 5) begin seen = 1'b1; break; end
    end
    check("mid_data_reached", seen, 1'b1);
    check("mid_err_cleared", oErr, 1'b0);
    RESET = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    iCall = 3'b000;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;
    exp_wr.delete();
    repeat (4) @(negedge CLOCK);
    check("post_reset_idle", {oFuncCall, SD_NCS}, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
